spi_nibble_rx: RTL and testbench

Receive stage directly downstream of `outputSPI` in the crypto datapath. It samples the 4-bit nibble link (`clk_out`, `en_out`, `out[3:0]`) in the system clock domain and reassembles nibble pairs into bytes. Completed bytes are buffered in a small FIFO and handed to the consumer over a valid/ready interface. Framing and overflow faults are reported as sticky flags.

---
 rtl/spi_link_pkg.sv | 22 ++
 rtl/byte_fifo.sv | 74 +++++++
 rtl/spi_nibble_rx.sv | 153 +++++++++++++++
 tb/tb_spi_nibble_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_link_pkg.sv
// rtl/spi_link_pkg.sv - shared nibble-link constants, FSM state type and byte assembly helper
package spi_link_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NIB0 = 2'd1,
        NIB1 = 2'd2
    } link_state_t;

    // msn_first selects whether the first nibble of a pair lands in bits [7:4] or [3:0]
    function automatic logic [BYTE_W-1:0] assemble_byte(
        input logic [NIBBLE_W-1:0] first,
        input logic [NIBBLE_W-1:0] second,
        input logic                msn_first
    );
        return msn_first ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous byte FIFO with registered head; push into a full FIFO succeeds only alongside a pop
module byte_fifo
    import spi_link_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [BYTE_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_inc;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign do_pop     = pop & ~empty;
    assign do_push    = push & (~full | do_pop);
    assign rd_ptr_inc = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // head tracks the entry at rd_ptr after this cycle's push/pop settle
            if (do_pop) begin
                if (count == CW'(1)) begin
                    if (do_push) begin
                        head <= push_data;
                    end
                end else begin
                    head <= mem[rd_ptr_inc];
                end
            end else if (do_push && empty) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/spi_nibble_rx.sv
// rtl/spi_nibble_rx.sv - nibble link receiver, byte reassembly and FIFO; SPI_NIBBLE_RX_SYNC_EN selects a two-flop input synchronizer
module spi_nibble_rx
    import spi_link_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit MSN_FIRST = 1'b1
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_clk,
    input  logic                spi_en,
    input  logic [NIBBLE_W-1:0] spi_data,
    output logic [BYTE_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                overflow,
    output logic                frame_err,
    input  logic                err_clr
);

    logic                link_clk;
    logic                link_en;
    logic [NIBBLE_W-1:0] link_data;
    logic                prev_clk;

`ifdef SPI_NIBBLE_RX_SYNC_EN
    logic                meta_clk;
    logic                meta_en;
    logic [NIBBLE_W-1:0] meta_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_clk  <= 1'b0;
            meta_en   <= 1'b0;
            meta_data <= '0;
            link_clk  <= 1'b0;
            link_en   <= 1'b0;
            link_data <= '0;
        end else begin
            meta_clk  <= spi_clk;
            meta_en   <= spi_en;
            meta_data <= spi_data;
            link_clk  <= meta_clk;
            link_en   <= meta_en;
            link_data <= meta_data;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            link_clk  <= 1'b0;
            link_en   <= 1'b0;
            link_data <= '0;
        end else begin
            link_clk  <= spi_clk;
            link_en   <= spi_en;
            link_data <= spi_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_clk <= 1'b0;
        end else begin
            prev_clk <= link_clk;
        end
    end

    link_state_t         state;
    logic [NIBBLE_W-1:0] first_nib;
    logic                strobe;
    logic                push;
    logic [BYTE_W-1:0]   push_data;
    logic                pop;
    logic                full;
    logic                empty;
    logic                overflow_set;
    logic                frame_err_set;

    assign strobe        = link_clk & ~prev_clk & link_en;
    assign push          = (state == NIB1) & strobe;
    assign push_data     = assemble_byte(first_nib, link_data, MSN_FIRST);
    assign rd_valid      = ~empty;
    assign pop           = rd_valid & rd_ready;
    assign overflow_set  = push & full & ~pop;
    assign frame_err_set = (state == NIB1) & ~link_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            first_nib <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (link_en) begin
                        state <= NIB0;
                    end
                end
                NIB0: begin
                    if (!link_en) begin
                        state <= IDLE;
                    end else if (strobe) begin
                        first_nib <= link_data;
                        state     <= NIB1;
                    end
                end
                NIB1: begin
                    if (!link_en) begin
                        state <= IDLE;
                    end else if (strobe) begin
                        state <= NIB0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // a set event in the same cycle as err_clr wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (frame_err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (rd_data)
    );

endmodule

// File: tb/tb_spi_nibble_rx.sv
// tb/tb_spi_nibble_rx.sv - directed bench for spi_nibble_rx (MSN_FIRST=1 and MSN_FIRST=0 instances)
module tb_spi_nibble_rx;

`ifdef SPI_NIBBLE_RX_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       spi_clk  = 1'b0;
    logic       spi_en   = 1'b0;
    logic [3:0] spi_data = 4'h0;
    logic       rd_ready = 1'b0;
    logic       err_clr  = 1'b0;

    logic [7:0] rd_data;
    logic       rd_valid;
    logic       overflow;
    logic       frame_err;
    logic [7:0] rd_data_l;
    logic       rd_valid_l;
    logic       overflow_l;
    logic       frame_err_l;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    spi_nibble_rx #(.DEPTH(4), .MSN_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_en(spi_en), .spi_data(spi_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr)
    );

    spi_nibble_rx #(.DEPTH(4), .MSN_FIRST(1'b0)) dut_lsn (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_en(spi_en), .spi_data(spi_data),
        .rd_data(rd_data_l), .rd_valid(rd_valid_l), .rd_ready(rd_ready),
        .overflow(overflow_l), .frame_err(frame_err_l), .err_clr(err_clr)
    );

    typedef struct {
        logic [3:0] n0;
        logic [3:0] n1;
        logic [7:0] exp_msn;
        logic [7:0] exp_lsn;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic start_frame();
        @(negedge clk) spi_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk) spi_en = 1'b0;
        repeat (S + 2) @(negedge clk);
    endtask

    // pop_on_push raises rd_ready in the strobe cycle so the pop meets the push edge
    task automatic send_nibble(input logic [3:0] n, input bit pop_on_push);
        @(negedge clk) spi_data = n;
        @(negedge clk) spi_clk = 1'b1;
        repeat (S) @(negedge clk);
        if (pop_on_push) rd_ready = 1'b1;
        @(negedge clk);
        if (pop_on_push) rd_ready = 1'b0;
        spi_clk = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check($sformatf("%s valid", name), rd_valid, 1);
        check($sformatf("%s data", name), rd_data, exp);
        rd_ready = 1'b1;
        @(negedge clk) rd_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'h0, 4'h1, 8'h01, 8'h10};
        vecs[1] = '{4'hA, 4'h5, 8'hA5, 8'h5A};
        vecs[2] = '{4'hF, 4'h0, 8'hF0, 8'h0F};
        vecs[3] = '{4'h3, 4'hC, 8'h3C, 8'hC3};
        vecs[4] = '{4'h9, 4'h6, 8'h96, 8'h69};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_data", rd_data, 8'h00);
        check("reset overflow", overflow, 0);
        check("reset frame_err", frame_err, 0);

        // basic frame with latency measurement on the first byte
        start_frame();
        send_nibble(4'h0, 0);
        @(negedge clk) spi_data = 4'h0;
        @(negedge clk) spi_clk = 1'b1;
        repeat (S) @(posedge clk);
        #1 check("latency before", rd_valid, 0);
        @(posedge clk);
        #1 check("latency at", rd_valid, 1);
        @(negedge clk) spi_clk = 1'b0;
        @(negedge clk);
        send_nibble(4'h0, 0); send_nibble(4'h1, 0);
        send_nibble(4'h0, 0); send_nibble(4'h2, 0);
        send_nibble(4'h0, 0); send_nibble(4'h3, 0);
        end_frame();
        check("basic overflow", overflow, 0);
        check("basic frame_err", frame_err, 0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("basic%0d", i), 8'(i));
        check("basic drained", rd_valid, 0);

        foreach (vecs[i]) begin
            start_frame();
            send_nibble(vecs[i].n0, 0);
            send_nibble(vecs[i].n1, 0);
            end_frame();
            check($sformatf("vec%0d msn valid", i), rd_valid, 1);
            check($sformatf("vec%0d msn data", i), rd_data, vecs[i].exp_msn);
            check($sformatf("vec%0d lsn valid", i), rd_valid_l, 1);
            check($sformatf("vec%0d lsn data", i), rd_data_l, vecs[i].exp_lsn);
            rd_ready = 1'b1;
            @(negedge clk) rd_ready = 1'b0;
            check($sformatf("vec%0d empty", i), rd_valid, 0);
        end

        // overflow: six bytes into a four-deep FIFO with no consumer
        start_frame();
        for (int i = 0; i < 6; i++) begin
            send_nibble(4'h0, 0);
            send_nibble(4'(i), 0);
        end
        end_frame();
        check("ovf flag", overflow, 1);
        check("ovf frame_err", frame_err, 0);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        check("ovf cleared", overflow, 0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovf%0d", i), 8'(i));
        check("ovf drained", rd_valid, 0);

        // full FIFO, fifth byte pushed on the same edge as a pop
        start_frame();
        for (int i = 0; i < 4; i++) begin
            send_nibble(4'h0, 0);
            send_nibble(4'(i), 0);
        end
        send_nibble(4'h4, 0);
        send_nibble(4'h4, 1);
        end_frame();
        check("fullpop overflow", overflow, 0);
        pop_check("fullpop0", 8'h01);
        pop_check("fullpop1", 8'h02);
        pop_check("fullpop2", 8'h03);
        pop_check("fullpop3", 8'h44);
        check("fullpop drained", rd_valid, 0);

        // frame error on an odd nibble count
        start_frame();
        send_nibble(4'h1, 0); send_nibble(4'h2, 0); send_nibble(4'h3, 0);
        end_frame();
        check("ferr flag", frame_err, 1);
        check("ferr overflow", overflow, 0);
        start_frame();
        send_nibble(4'h4, 0); send_nibble(4'h5, 0);
        end_frame();
        pop_check("ferr0", 8'h12);
        pop_check("ferr1", 8'h45);
        check("ferr drained", rd_valid, 0);
        check("ferr sticky", frame_err, 1);

        // reset mid-byte with two bytes queued
        start_frame();
        send_nibble(4'h1, 0); send_nibble(4'h1, 0);
        send_nibble(4'h2, 0); send_nibble(4'h2, 0);
        send_nibble(4'h3, 0);
        check("prerst valid", rd_valid, 1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_data", rd_data, 8'h00);
        check("rst overflow", overflow, 0);
        check("rst frame_err", frame_err, 0);
        @(negedge clk) rst_n = 1'b1;
        send_nibble(4'h7, 0); send_nibble(4'hE, 0);
        end_frame();
        pop_check("postrst", 8'h7E);
        check("postrst drained", rd_valid, 0);
        check("postrst frame_err", frame_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
